word_feeder: RTL and testbench

WORD_FEEDER -- requirements
Module: word_feeder

---
 rtl/word_feeder.sv | 70 +++++++
 tb/tb_word_feeder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/word_feeder.sv
// word_feeder: packs bytes little-endian into 32-bit words and queues them in a 2-entry output FIFO.
// Define WORD_FEEDER_FLUSH_EN to add an idle-timeout flush of zero-padded partial words.
module word_feeder #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic [31:0] WORD_OUT,
  output logic        WORD_VALID,
  input  logic        BUSY,
  output logic [1:0]  LEVEL,
  output logic        WORD_PARTIAL
);
  typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} state_t;
  state_t      r_cnt, w_cnt_n;
  logic [1:0]  r_lvl, w_l;
  logic [23:0] r_asm;
  logic [32:0] r_e0, r_e1, w_new, w_s0, w_s1;
  logic        w_acc, w_pop, w_push, w_flush;
  assign BYTE_READY   = ~RST & ((r_cnt != FILL3) | (r_lvl != 2'd2));
  assign w_acc        = BYTE_VALID & BYTE_READY;
  assign w_pop        = (r_lvl != 2'd0) & ~BUSY;
  assign w_push       = (w_acc & (r_cnt == FILL3)) | w_flush;
  assign w_new        = w_flush ? {1'b1, 8'h00, r_asm} : {1'b0, BYTE_IN, r_asm};
  // Entries beyond the level are kept zero, so a pop simply shifts the tail forward.
  assign w_s0         = w_pop ? r_e1 : r_e0;
  assign w_s1         = w_pop ? 33'h0 : r_e1;
  assign w_l          = r_lvl - {1'b0, w_pop};
  assign WORD_OUT     = r_e0[31:0];
  assign WORD_PARTIAL = r_e0[32];
  assign WORD_VALID   = r_lvl != 2'd0;
  assign LEVEL        = r_lvl;
  always_comb begin
    w_cnt_n = r_cnt;
    if (w_acc) w_cnt_n = state_t'(r_cnt + 2'd1);
    else if (w_flush) w_cnt_n = FILL0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= FILL0;
      r_asm <= '0;
      r_e0  <= '0;
      r_e1  <= '0;
      r_lvl <= '0;
    end else begin
      r_cnt <= w_cnt_n;
      r_asm <= w_push ? 24'h0 : w_acc ? r_asm | ({16'h0, BYTE_IN} << {r_cnt, 3'b000}) : r_asm;
      r_e0  <= (w_push && w_l == 2'd0) ? w_new : w_s0;
      r_e1  <= (w_push && w_l == 2'd1) ? w_new : w_s1;
      r_lvl <= w_l + {1'b0, w_push};
    end
  end
`ifdef WORD_FEEDER_FLUSH_EN
  logic [7:0] r_tmr;
  logic       w_idle, w_hit;
  assign w_idle  = (r_cnt != FILL0) & ~w_acc;
  assign w_hit   = w_idle & (r_tmr >= 8'(TIMEOUT - 1));
  assign w_flush = w_hit & (r_lvl != 2'd2);
  // A blocked flush holds the timer at its threshold until the buffer has room.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_tmr <= '0;
    else r_tmr <= (~w_idle | w_flush) ? 8'h0 : w_hit ? r_tmr : r_tmr + 8'h1;
  end
`else
  assign w_flush = 1'b0;
`endif
endmodule

// File: tb/tb_word_feeder.sv
// tb_word_feeder: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_word_feeder;
  logic        CLK = 0, RST = 1, BYTE_VALID = 0, BUSY = 0;
  logic [7:0]  BYTE_IN = 0;
  logic        BYTE_READY, WORD_VALID, WORD_PARTIAL;
  logic [31:0] WORD_OUT;
  logic [1:0]  LEVEL;
  logic [32:0] exp_q[$];
  int checks = 0, errors = 0;
  logic [31:0] held;

  word_feeder #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .WORD_OUT(WORD_OUT), .WORD_VALID(WORD_VALID),
    .BUSY(BUSY), .LEVEL(LEVEL), .WORD_PARTIAL(WORD_PARTIAL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word transfers happen at the posedge following a negedge that sees VALID & !BUSY.
  always @(negedge CLK) begin
    if (!RST && WORD_VALID && !BUSY) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h expected none", WORD_OUT);
      end else chk("word_out", {WORD_PARTIAL, WORD_OUT}, exp_q.pop_front());
    end
    if (!WORD_VALID) chk("idle_zero", {WORD_PARTIAL, WORD_OUT}, 33'h0);
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic r;
    BYTE_IN = b; BYTE_VALID = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK); r = BYTE_READY;
      @(posedge CLK); #1;
      if (r) return;
    end
    checks++; errors++;
    $display("FAIL send_timeout: byte %h not accepted expected accept", b);
  endtask

  task automatic idle();
    BYTE_VALID = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
    chk("drained", 33'(exp_q.size()), 33'h0);
  endtask

  initial begin
    #12;
    chk("rst_out", {WORD_PARTIAL, WORD_OUT}, 33'h0);
    chk("rst_valid_level_ready", {30'h0, WORD_VALID, LEVEL}, 33'h0);
    chk("rst_ready", 33'(BYTE_READY), 33'h0);
    @(posedge CLK); #1 RST = 0;
    @(negedge CLK);
    chk("ready_after_rst", 33'(BYTE_READY), 33'h1);
    step();

    // back-to-back word, single-cycle valid
    exp_q.push_back({1'b0, 32'h44332211});
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); idle();
    chk("latency_valid", 33'(WORD_VALID), 33'h1);
    chk("latency_word", 33'(WORD_OUT), 33'h44332211);
    step();
    chk("one_cycle_valid", 33'(WORD_VALID), 33'h0);
    drain();

    // backpressure fills buffer
    BUSY = 1;
    exp_q.push_back({1'b0, 32'h03020100});
    exp_q.push_back({1'b0, 32'h07060504});
    exp_q.push_back({1'b0, 32'h0B0A0908});
    for (int i = 0; i < 11; i++) send(8'(i));
    BYTE_IN = 8'h0B; BYTE_VALID = 1;
    held = WORD_OUT;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("full_level", 33'(LEVEL), 33'h2);
      chk("full_ready", 33'(BYTE_READY), 33'h0);
      chk("busy_stable", 33'(WORD_OUT), 33'(held));
    end
    @(posedge CLK); #1 BUSY = 0;
    send(8'h0B); idle();
    drain();

    // simultaneous push and pop at level 1
    BUSY = 1;
    exp_q.push_back({1'b0, 32'hA3A2A1A0});
    exp_q.push_back({1'b0, 32'hB3B2B1B0});
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    send(8'hB0); send(8'hB1); send(8'hB2);
    chk("pp_level_before", 33'(LEVEL), 33'h1);
    BUSY = 0;
    send(8'hB3); idle(); BUSY = 1;
    chk("pp_level_after", 33'(LEVEL), 33'h1);
    chk("pp_head", 33'(WORD_OUT), 33'hB3B2B1B0);
    BUSY = 0;
    drain();

    // reset discards buffered and partial data
    BUSY = 1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); idle();
    chk("pre_rst_level", 33'(LEVEL), 33'h1);
    #2 RST = 1; #1;
    chk("async_rst_out", {WORD_PARTIAL, WORD_OUT}, 33'h0);
    chk("async_rst_valid_level", {31'h0, WORD_VALID, LEVEL[1] | LEVEL[0]}, 33'h0);
    step(); RST = 0; BUSY = 0;
    step();
    exp_q.push_back({1'b0, 32'hDDCCBBAA});
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); idle();
    drain();

    // partial word then long idle
    send(8'h5A); send(8'hA5); idle();
`ifdef WORD_FEEDER_FLUSH_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk("no_early_flush", 33'(WORD_VALID), 33'h0);
    end
    exp_q.push_back({1'b1, 32'h0000A55A});
    @(negedge CLK);
    chk("flush_valid", 33'(WORD_VALID), 33'h1);
    drain();
`else
    repeat (100) @(posedge CLK);
    #1 chk("no_flush_level", 33'(LEVEL), 33'h0);
`endif
    repeat (5) step();
    chk("final_queue", 33'(exp_q.size()), 33'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim did not finish expected finish");
    $fatal(1);
  end
endmodule
